tmds_rx_decoder: RTL and testbench
==================================

Name: tmds_rx_decoder

Overview:
Receive-side counterpart of the TMDS channel encoder: decodes one TMDS channel and recovers its word alignment.
- Input: raw 10-bit parallel words from a per-channel 1:10 deserializer, in the hdmi_clk domain.
- Output: 8-bit pixel data, DE and C[1:0].
- Drives a bitslip pulse back to the deserializer until word alignment is found, using control-token runs in blanking.
- One instance per channel; channel 0 recovers hsync/vsync from C[1:0].

Parameters:
CTRL_RUN, 8, consecutive identical control tokens required to declare/refresh alignment
SEARCH_TIMEOUT, 2048, cycles without a qualifying run before slipping (SEARCH) or dropping lock (LOCKED); must exceed one line (1048)
SLIP_WAIT, 16, settle cycles after each bitslip pulse

Ports:
hdmi_clk  in  1  pixel clock
rst  in  1  reset
din  in  10  raw TMDS word from deserializer, bit 0 first on the wire
bitslip  out  1  one-cycle request to rotate deserializer word boundary by one bit
locked  out  1  word alignment valid
de  out  1  data enable (data period)
c  out  2  control bits during blanking
dout  out  8  decoded pixel byte
slip_cnt  out  8  saturating slip count (see Optional Feature)

Behaviour:
- Reset: rst is synchronous, active-high; clock is hdmi_clk. On reset: bitslip=0, locked=0, de=0, c=0, dout=0, slip_cnt=0, all counters 0, FSM=SEARCH.
- Token classification (combinational on din):
  - 0x354→C=00, 0x0AB→C=01, 0x154→C=10, 0x2AB→C=11.
  - Any other value is a data word.
- Data decode:
  - If din[9]=1, invert din[7:0], giving q.
  - d[0]=q[0].
  - For i=1..7: if din[8]=1, d[i]=q[i]^q[i-1]; else d[i]=~(q[i]^q[i-1]).
- Output latency: de/c/dout are registered, with exactly 1 cycle latency from din.
  - Control word: de=0, c=token value, dout holds its previous value.
  - Data word: de=1, c holds its previous value, dout=d.
  - While locked=0, de/c/dout are forced to 0.
- Run counter:
  - Increments when din is a control token equal to the previous cycle's token; otherwise reloads to 1 for a token, 0 for data.
  - Saturates at CTRL_RUN.
  - "Qualifying run" = counter reaches CTRL_RUN.
- Timeout counter:
  - Cleared on a qualifying run; otherwise increments each cycle.
  - Cleared on every state entry.
- FSM:
  - SEARCH:
    - Qualifying run → LOCKED; locked=1 from the next cycle.
    - Timeout reaches SEARCH_TIMEOUT → assert bitslip for exactly 1 cycle, go to SLIP_WAIT.
  - SLIP_WAIT:
    - Count SLIP_WAIT cycles, ignoring din; run counter held at 0.
    - Then → SEARCH.
  - LOCKED:
    - Qualifying run clears timeout.
    - Timeout reaches SEARCH_TIMEOUT → locked=0 next cycle, go to SEARCH; no slip on this transition.
- Simultaneous events: a qualifying run in the same cycle as a timeout wins; no slip, no lock loss.
- bitslip is never asserted in LOCKED, never on consecutive cycles, and never twice within SLIP_WAIT+1 cycles.
- Reset mid-slip or mid-lock returns to the full reset state on the next edge.

Optional Feature:
Macro TMDS_RX_SLIP_STATS_EN.
- Defined: slip_cnt increments on each bitslip pulse, saturating at 255, and clears only on rst. Lets lab debug confirm deserializer alignment effort.
- Undefined: slip_cnt is driven constant 0 and no counter logic is synthesized.

Test Plan:
1. Aligned stream, 400 x 0x354 then 640 data words of 0x100 → locked=1 after the 8th token; during data de=1, dout=0x00; bitslip never asserted.
2. Data words 0x200 and 0x100 alternating after lock → dout alternates 0xFF/0x00 with 1-cycle latency; de=1 throughout.
3. Stream rotated by k=3 bits (bench deserializer model rotates by 1 per bitslip) → exactly 3 bitslip pulses, each ≥17 cycles apart. Then locked=1; slip_cnt=3 with TMDS_RX_SLIP_STATS_EN, 0 without.
4. Locked, then 2100 cycles of data only (no control tokens) → locked drops at timeout 2048; de/c/dout forced to 0; no bitslip in that cycle.
5. Tokens 0x154 x4, 0x2AB x4, 0x0AB x8 in SEARCH → lock only after the 0x0AB run completes; c=01 one cycle after lock.
6. rst asserted for 1 cycle while in SLIP_WAIT with slip_cnt=5 → next cycle all outputs 0, slip_cnt=0, FSM=SEARCH.

Source files
------------

// File: rtl/tmds_rx_decoder.sv
// tmds_rx_decoder: one TMDS channel receiver that decodes 10-bit words to pixel data and control bits, and recovers word alignment.
//   hdmi_clk  pixel clock
//   rst       synchronous active-high reset
//   din       raw 10-bit word from the deserializer, bit 0 first on the wire
//   bitslip   one-cycle request to rotate the deserializer word boundary by one bit
//   locked    word alignment valid
//   de        data enable (data period)
//   c         control bits during blanking
//   dout      decoded pixel byte
//   slip_cnt  saturating bitslip count, kept only when TMDS_RX_SLIP_STATS_EN is defined (constant 0 otherwise)
module tmds_rx_decoder #(
  parameter int CTRL_RUN       = 8,
  parameter int SEARCH_TIMEOUT = 2048,
  parameter int SLIP_WAIT      = 16
) (
  input  logic       hdmi_clk,
  input  logic       rst,
  input  logic [9:0] din,
  output logic       bitslip,
  output logic       locked,
  output logic       de,
  output logic [1:0] c,
  output logic [7:0] dout,
  output logic [7:0] slip_cnt
);
  localparam int RW = $clog2(CTRL_RUN + 1);
  localparam int TW = $clog2(SEARCH_TIMEOUT + 1);
  localparam int WW = $clog2(SLIP_WAIT + 1);
  typedef enum logic [1:0] {ST_SEARCH, ST_WAIT, ST_LOCKED} state_t;
  state_t state, state_n;
  logic is_tok, qual, tmo, slip_n, lk_n;
  logic [1:0] tok, prev_tok;
  logic [7:0] q, d;
  logic [RW-1:0] run_cnt, run_n;
  logic [TW-1:0] to_cnt, to_n;
  logic [WW-1:0] wait_cnt, wait_n;
  always_comb begin
    is_tok = 1'b1;
    tok = 2'd0;
    case (din)
      10'h354: tok = 2'd0;
      10'h0ab: tok = 2'd1;
      10'h154: tok = 2'd2;
      10'h2ab: tok = 2'd3;
      default: is_tok = 1'b0;
    endcase
  end
  assign q = din[9] ? ~din[7:0] : din[7:0];
  assign d = {din[8] ? q[7:1] ^ q[6:0] : ~(q[7:1] ^ q[6:0]), q[0]};
  // a zero run count doubles as "previous word was not a token", so prev_tok is only trusted when it is nonzero
  assign run_n = (state == ST_WAIT || !is_tok) ? '0
               : (run_cnt == '0 || tok != prev_tok) ? RW'(1)
               : (run_cnt == RW'(CTRL_RUN)) ? run_cnt : run_cnt + 1'b1;
  assign qual = run_n == RW'(CTRL_RUN);
  assign tmo = to_cnt == TW'(SEARCH_TIMEOUT - 1);
  always_comb begin
    state_n = state;
    slip_n = 1'b0;
    case (state)
      ST_SEARCH: begin
        if (qual) state_n = ST_LOCKED;
        else if (tmo) begin
          state_n = ST_WAIT;
          slip_n = 1'b1;
        end
      end
      ST_WAIT: if (wait_cnt == WW'(SLIP_WAIT - 1)) state_n = ST_SEARCH;
      ST_LOCKED: if (!qual && tmo) state_n = ST_SEARCH;
      default: state_n = ST_SEARCH;
    endcase
  end
  // outputs are gated by the next state so de/c/dout are zero exactly when locked is
  assign lk_n = state_n == ST_LOCKED;
  assign to_n = (state_n != state || qual) ? '0 : to_cnt + 1'b1;
  assign wait_n = (state == ST_WAIT && state_n == state) ? wait_cnt + 1'b1 : '0;
  always_ff @(posedge hdmi_clk) begin
    if (rst) begin
      state <= ST_SEARCH;
      run_cnt <= '0;
      prev_tok <= 2'd0;
      to_cnt <= '0;
      wait_cnt <= '0;
      bitslip <= 1'b0;
      locked <= 1'b0;
      de <= 1'b0;
      c <= 2'd0;
      dout <= 8'd0;
    end else begin
      state <= state_n;
      run_cnt <= run_n;
      prev_tok <= tok;
      to_cnt <= to_n;
      wait_cnt <= wait_n;
      bitslip <= slip_n;
      locked <= lk_n;
      de <= lk_n && !is_tok;
      c <= !lk_n ? 2'd0 : is_tok ? tok : c;
      dout <= !lk_n ? 8'd0 : is_tok ? dout : d;
    end
  end
`ifdef TMDS_RX_SLIP_STATS_EN
  always_ff @(posedge hdmi_clk) begin
    if (rst) slip_cnt <= 8'd0;
    else if (slip_n && slip_cnt != 8'hff) slip_cnt <= slip_cnt + 8'd1;
  end
`else
  assign slip_cnt = 8'd0;
`endif
endmodule

// File: tb/tb_tmds_rx_decoder.sv
// tb_tmds_rx_decoder: self-checking bench for tmds_rx_decoder with a cycle-level reference model and a rotating deserializer model.
module tb_tmds_rx_decoder;
  localparam int CTRL_RUN = 8;
  localparam int TMO = 2048;
  localparam int SW = 16;
  logic hdmi_clk = 1'b0;
  logic rst = 1'b1;
  logic [9:0] din = 10'd0;
  logic bitslip, locked, de;
  logic [1:0] c;
  logic [7:0] dout, slip_cnt;
  int tests = 0;
  int fails = 0;
  int mode = 0;
  int streak = 0;
  int last_tok = -1;
  int idle = 0;
  int waitc = 0;
  int e_slipn = 0;
  logic e_lk = 1'b0;
  logic e_bs = 1'b0;
  logic e_de = 1'b0;
  logic [1:0] e_c = 2'd0;
  logic [7:0] e_dout = 8'd0;
  int offset = 0;
  logic [9:0] prev_w = 10'd0;
  int cyc = 0;
  int slips = 0;
  int last_slip = -1000;
  int min_gap = 1000000;
  int drop_at = -1;
  tmds_rx_decoder dut (
    .hdmi_clk(hdmi_clk),
    .rst(rst),
    .din(din),
    .bitslip(bitslip),
    .locked(locked),
    .de(de),
    .c(c),
    .dout(dout),
    .slip_cnt(slip_cnt)
  );
  always #5 hdmi_clk = ~hdmi_clk;
  function automatic int tok_of(input logic [9:0] w);
    case (w)
      10'h354: return 0;
      10'h0ab: return 1;
      10'h154: return 2;
      10'h2ab: return 3;
      default: return -1;
    endcase
  endfunction
  function automatic logic [7:0] decode(input logic [9:0] w);
    logic [7:0] q, r;
    q = w[9] ? ~w[7:0] : w[7:0];
    r[0] = q[0];
    for (int i = 1; i < 8; i++) r[i] = q[i] ^ q[i-1] ^ ~w[8];
    return r;
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask
  task automatic model_reset();
    mode = 0;
    streak = 0;
    last_tok = -1;
    idle = 0;
    waitc = 0;
    e_slipn = 0;
    e_lk = 1'b0;
    e_bs = 1'b0;
    e_de = 1'b0;
    e_c = 2'd0;
    e_dout = 8'd0;
    offset = 0;
    prev_w = 10'd0;
    slips = 0;
    last_slip = -1000;
    min_gap = 1000000;
  endtask
  task automatic check_outputs();
    chk("locked", locked, e_lk);
    chk("bitslip", bitslip, e_bs);
    chk("de", de, e_de);
    chk("c", c, e_c);
    chk("dout", dout, e_dout);
`ifdef TMDS_RX_SLIP_STATS_EN
    chk("slip_cnt", slip_cnt, e_slipn);
`else
    chk("slip_cnt", slip_cnt, 0);
`endif
  endtask
  task automatic do_reset();
    rst = 1'b1;
    din = 10'd0;
    @(posedge hdmi_clk);
    #1;
    cyc++;
    rst = 1'b0;
    model_reset();
    chk("rst_locked", locked, 0);
    chk("rst_bitslip", bitslip, 0);
    chk("rst_de", de, 0);
    chk("rst_c", c, 0);
    chk("rst_dout", dout, 0);
    chk("rst_slip_cnt", slip_cnt, 0);
  endtask
  // mode: 0 searching, 1 settling after a slip, 2 aligned
  task automatic step(input logic [9:0] w);
    logic [9:0] r;
    logic [19:0] pair;
    int tv, nm;
    bit qf;
    pair = {w, prev_w};
    r = offset == 0 ? w : 10'(pair >> (10 - offset));
    prev_w = w;
    din = r;
    tv = tok_of(r);
    if (mode == 1 || tv < 0) streak = 0;
    else if (streak > 0 && tv == last_tok) streak++;
    else streak = 1;
    last_tok = tv;
    qf = mode != 1 && streak >= CTRL_RUN;
    nm = mode;
    e_bs = 1'b0;
    if (qf) begin
      idle = 0;
      if (mode == 0) nm = 2;
    end else begin
      idle++;
      if (idle == TMO && mode != 1) begin
        nm = mode == 0 ? 1 : 0;
        e_bs = mode == 0;
      end
    end
    if (mode == 1) begin
      waitc++;
      if (waitc == SW) nm = 0;
    end
    if (nm != mode) begin
      idle = 0;
      waitc = 0;
    end
    mode = nm;
    e_lk = mode == 2;
    e_de = e_lk && tv < 0;
    e_c = !e_lk ? 2'd0 : tv >= 0 ? 2'(tv) : e_c;
    e_dout = !e_lk ? 8'd0 : tv >= 0 ? e_dout : decode(r);
    if (e_bs && e_slipn < 255) e_slipn++;
    @(posedge hdmi_clk);
    #1;
    cyc++;
    check_outputs();
    if (bitslip) begin
      slips++;
      if (cyc - last_slip < min_gap) min_gap = cyc - last_slip;
      last_slip = cyc;
      offset = (offset + 9) % 10;
    end
  endtask
  initial begin
    #1;
    do_reset();
    for (int i = 0; i < 7; i++) step(10'h354);
    chk("t1_not_yet_locked", locked, 0);
    step(10'h354);
    chk("t1_locked_after_8", locked, 1);
    chk("t1_c_after_lock", c, 0);
    for (int i = 0; i < 392; i++) step(10'h354);
    for (int i = 0; i < 640; i++) step(10'h100);
    chk("t1_de", de, 1);
    chk("t1_dout", dout, 8'h00);
    chk("t1_no_slip", slips, 0);
    for (int i = 0; i < 32; i++) begin
      step(10'h200);
      chk("t2_dout_ff", dout, 8'hff);
      step(10'h100);
      chk("t2_dout_00", dout, 8'h00);
      chk("t2_de", de, 1);
    end
    for (int i = 0; i < 2100; i++) begin
      step(10'h100);
      if (!locked && drop_at < 0) begin
        drop_at = i + 1;
        chk("t4_drop_de", de, 0);
        chk("t4_drop_c", c, 0);
        chk("t4_drop_dout", dout, 0);
        chk("t4_drop_bitslip", bitslip, 0);
      end
    end
    chk("t4_drop_at", drop_at, TMO - 704);
    chk("t4_no_slip", slips, 0);
    do_reset();
    for (int i = 0; i < 4; i++) step(10'h154);
    for (int i = 0; i < 4; i++) step(10'h2ab);
    for (int i = 0; i < 7; i++) step(10'h0ab);
    chk("t5_not_yet_locked", locked, 0);
    step(10'h0ab);
    chk("t5_locked", locked, 1);
    chk("t5_c", c, 2'b01);
    step(10'h0ab);
    chk("t5_c_hold", c, 2'b01);
    do_reset();
    offset = 3;
    for (int i = 0; i < 10000 && !locked; i++) step(10'h354);
    chk("t3_locked", locked, 1);
    chk("t3_slips", slips, 3);
    chk("t3_gap_ge_17", min_gap >= 17, 1);
`ifdef TMDS_RX_SLIP_STATS_EN
    chk("t3_slip_cnt", slip_cnt, 3);
`else
    chk("t3_slip_cnt", slip_cnt, 0);
`endif
    do_reset();
    for (int i = 0; i < 12000 && slips < 5; i++) step(10'h100);
    chk("t6_slips", slips, 5);
    for (int i = 0; i < 3; i++) step(10'h100);
`ifdef TMDS_RX_SLIP_STATS_EN
    chk("t6_slip_cnt_pre", slip_cnt, 5);
`else
    chk("t6_slip_cnt_pre", slip_cnt, 0);
`endif
    do_reset();
    for (int i = 0; i < 8; i++) step(10'h354);
    chk("t6_relock_from_search", locked, 1);
    chk("t6_no_slip_after_rst", slips, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
